// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Issues one byte per frame and holds
// tx_data stable from issue until the transmitter reports idle again.
module uart_tx_fifo #(
    parameter int unsigned  DEPTH   = 8,
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               flush,
    input  logic               tx_en,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic               tx_data_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic                 overflow_q;
    logic                 valid_q, valid_d;
    logic [7:0]           data_q, data_d;
    logic                 push, pop;

    assign full          = (level_q == LEVEL_W'(DEPTH));
    assign empty         = (level_q == '0);
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign tx_data_valid = valid_q;
    assign tx_data       = data_q;

    // Flush overrides any write in the same cycle, so it also suppresses overflow.
    assign push = wr_en && !full && !flush;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A byte being flushed this cycle must not be issued either.
                if (tx_en && !empty && !tx_busy && !flush) begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    data_d  = mem[rd_ptr_q];
                    state_d = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    valid_d = 1'b0;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            overflow_q <= wr_en && full && !flush;
            valid_q    <= valid_d;
            data_q     <= data_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model that
// records every accepted frame and watches tx_data stability while busy.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst, wr_en, flush, tx_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, tx_data_valid;
    logic [3:0] level;
    logic [7:0] tx_data;
    logic       tx_busy;

    logic       model_busy, force_busy;
    logic       prev_valid, prev_busy;
    logic [7:0] cur_byte;
    int         busy_cnt;
    int         frame_len = 4;
    int         stab_err  = 0;
    int         issue_err = 0;
    logic [7:0] rx_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign tx_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .flush         (flush),
        .tx_en         (tx_en),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy)
    );

    // Transmitter model: starts a frame when idle and valid is seen, stays busy frame_len cycles.
    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
            prev_valid <= 1'b0;
            prev_busy  <= 1'b0;
        end else begin
            prev_valid <= tx_data_valid;
            prev_busy  <= tx_busy;
            if (tx_data_valid && !prev_valid && prev_busy) issue_err <= issue_err + 1;
            if (model_busy) begin
                if (tx_data !== cur_byte) stab_err <= stab_err + 1;
                if (busy_cnt <= 1) model_busy <= 1'b0;
                else busy_cnt <= busy_cnt - 1;
            end else if (tx_data_valid) begin
                model_busy <= 1'b1;
                busy_cnt   <= frame_len;
                cur_byte   <= tx_data;
                rx_q.push_back(tx_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_en = 1'b1;
        force_busy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_checks++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", tx_data_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", tx_data); end
    endtask

    task automatic test_single();
        rx_q.delete();
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        n_checks++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", tx_data_valid); end
        n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level1 got %0d want 1", level); end
        tick();
        n_checks++; if (tx_data_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", tx_data_valid); end
        n_checks++; if (tx_data !== 8'h55) begin n_fail++; $display("FAIL single_data got %h want 55", tx_data); end
        n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_level0 got %0d want 0", level); end
        for (int i = 0; i < 20 && tx_data_valid; i++) tick();
        n_checks++; if (tx_data_valid !== 1'b0 || tx_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_drop valid=%b busy=%b want valid=0 busy=1", tx_data_valid, tx_busy);
        end
        repeat (frame_len + 6) tick();
        n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            n_fail++; $display("FAIL single_rx got size %0d want one byte 55", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        bit ok;
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
        rx_q.delete();
        force_busy = 1'b1;
        tick();
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = exp[i];
            tick();
        end
        wr_en = 1'b0;
        repeat (5) tick();
        n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL b2b_level got %0d want 3", level); end
        n_checks++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_held got %b want 0", tx_data_valid); end
        force_busy = 1'b0;
        wait_rx(3, 300, ok);
        repeat (frame_len + 6) tick();
        n_checks++; if (!ok || rx_q.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_order[%0d] got %h want %h", i, rx_q[i], exp[i]); end
        end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL b2b_stable got %0d errors want 0", stab_err); end
        n_checks++; if (issue_err != 0) begin n_fail++; $display("FAIL b2b_issue_busy got %0d want 0", issue_err); end
    endtask

    task automatic test_overflow();
        bit ok;
        rx_q.delete();
        force_busy = 1'b1;
        tick();
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'h30 + 8'(i);
            tick();
            if (i == 6) begin
                n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL ovf_full7 got %b want 0", full); end
            end
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full8 got %b want 1", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow); end
        wr_data = 8'h38;
        tick();
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", overflow); end
        n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", level); end
        tick();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %b want 0", overflow); end
        force_busy = 1'b0;
        wait_rx(8, 600, ok);
        repeat (3 * frame_len + 10) tick();
        n_checks++; if (!ok || rx_q.size() != 8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", rx_q.size()); end
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== 8'h30 + 8'(i)) begin n_fail++; $display("FAIL ovf_order[%0d] got %h want %h", i, rx_q[i], 8'h30 + 8'(i)); end
        end
    endtask

    task automatic test_flush();
        rx_q.delete();
        frame_len = 30;
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'h60 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        n_checks++; if (level !== 4'd5) begin n_fail++; $display("FAIL flush_pre_level got %0d want 5", level); end
        n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL flush_inflight busy=%b want 1", tx_busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (level !== 4'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL flush_clear level=%0d empty=%b want 0/1", level, empty);
        end
        repeat (80) tick();
        n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h60) begin
            n_fail++; $display("FAIL flush_inflight_done got size %0d want one byte 60", rx_q.size());
        end
        frame_len = 4;
        // Fill completely, then flush with a write: no overflow, nothing left.
        force_busy = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'h80 + 8'(i);
            tick();
        end
        flush = 1'b1; wr_data = 8'h99;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        n_checks++; if (level !== 4'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL flush_wr level=%0d overflow=%b want 0/0", level, overflow);
        end
        force_busy = 1'b0;
        repeat (30) tick();
        n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL flush_no_issue got size %0d want 1", rx_q.size()); end
    endtask

    task automatic test_tx_en();
        int vcount;
        bit ok;
        rx_q.delete();
        tx_en = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'h71 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        vcount = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_data_valid) vcount++;
            tick();
        end
        n_checks++; if (vcount != 0) begin n_fail++; $display("FAIL txen_blocked got %0d valid cycles want 0", vcount); end
        n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL txen_level got %0d want 3", level); end
        tx_en = 1'b1;
        tick();
        n_checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h71) begin
            n_fail++; $display("FAIL txen_issue valid=%b data=%h want 1/71", tx_data_valid, tx_data);
        end
        wait_rx(3, 300, ok);
        repeat (frame_len + 6) tick();
        n_checks++; if (!ok || rx_q.size() != 3 || rx_q[2] !== 8'h73) begin
            n_fail++; $display("FAIL txen_drain got size %0d want 3 ending 73", rx_q.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int wait_fail;
        rx_q.delete();
        frame_len = 3;
        wait_fail = 0;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            for (int j = 0; j < 200 && full; j++) tick();
            if (full) wait_fail++;
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            wr_en = 1'b0;
        end
        n_checks++; if (wait_fail != 0) begin n_fail++; $display("FAIL wrap_space got %0d timeouts want 0", wait_fail); end
        wait_rx(20, 2000, ok);
        repeat (frame_len + 20) tick();
        n_checks++; if (!ok || rx_q.size() != 20) begin n_fail++; $display("FAIL wrap_count got %0d want 20", rx_q.size()); end
        for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== 8'(i)) begin n_fail++; $display("FAIL wrap_order[%0d] got %h want %h", i, rx_q[i], 8'(i)); end
        end
        n_checks++; if (stab_err != 0 || issue_err != 0) begin
            n_fail++; $display("FAIL wrap_protocol stab=%0d issue=%0d want 0/0", stab_err, issue_err);
        end
        frame_len = 4;
    endtask

    task automatic test_reset_mid();
        rx_q.delete();
        frame_len = 20;
        wr_en = 1'b1;
        wr_data = 8'hD1; tick();
        wr_data = 8'hD2; tick();
        wr_en = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (level !== 4'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_level level=%0d empty=%b want 0/1", level, empty);
        end
        n_checks++; if (tx_data_valid !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_out valid=%b data=%h want 0/00", tx_data_valid, tx_data);
        end
        repeat (40) tick();
        n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL rstmid_no_issue got size %0d want 1", rx_q.size()); end
        frame_len = 4;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_tx_en();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
